// File: rtl/axil_arb_2x1.sv
// Two-requester AXI-lite arbiter: independent round-robin write and read paths,
// one outstanding transaction per path, AW/W/AR passed through to the shared slave.
module axil_arb_2x1 #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH/8
) (
    input  logic                  clk,
    input  logic                  rst,
    // requester 0
    input  logic [ADDR_WIDTH-1:0] s00_axil_awaddr,
    input  logic [2:0]            s00_axil_awprot,
    input  logic                  s00_axil_awvalid,
    output logic                  s00_axil_awready,
    input  logic [DATA_WIDTH-1:0] s00_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s00_axil_wstrb,
    input  logic                  s00_axil_wvalid,
    output logic                  s00_axil_wready,
    output logic [1:0]            s00_axil_bresp,
    output logic                  s00_axil_bvalid,
    input  logic                  s00_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s00_axil_araddr,
    input  logic [2:0]            s00_axil_arprot,
    input  logic                  s00_axil_arvalid,
    output logic                  s00_axil_arready,
    output logic [DATA_WIDTH-1:0] s00_axil_rdata,
    output logic [1:0]            s00_axil_rresp,
    output logic                  s00_axil_rvalid,
    input  logic                  s00_axil_rready,
    // requester 1
    input  logic [ADDR_WIDTH-1:0] s01_axil_awaddr,
    input  logic [2:0]            s01_axil_awprot,
    input  logic                  s01_axil_awvalid,
    output logic                  s01_axil_awready,
    input  logic [DATA_WIDTH-1:0] s01_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s01_axil_wstrb,
    input  logic                  s01_axil_wvalid,
    output logic                  s01_axil_wready,
    output logic [1:0]            s01_axil_bresp,
    output logic                  s01_axil_bvalid,
    input  logic                  s01_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s01_axil_araddr,
    input  logic [2:0]            s01_axil_arprot,
    input  logic                  s01_axil_arvalid,
    output logic                  s01_axil_arready,
    output logic [DATA_WIDTH-1:0] s01_axil_rdata,
    output logic [1:0]            s01_axil_rresp,
    output logic                  s01_axil_rvalid,
    input  logic                  s01_axil_rready,
    // shared downstream slave
    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready,
    output logic [1:0]            wr_grant,
    output logic [1:0]            rd_grant
);

    typedef enum logic [1:0] {WR_IDLE = 2'd0, WR_XFER = 2'd1, WR_RESP = 2'd2} wr_state_t;
    typedef enum logic [1:0] {RD_IDLE = 2'd0, RD_XFER = 2'd1, RD_RESP = 2'd2} rd_state_t;

    // Round-robin pick: on contention the port that did not win last time goes first.
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last_one);
        logic [1:0] pick;
        if (req == 2'b11) begin
            pick = last_one ? 2'b01 : 2'b10;
        end else begin
            pick = req;
        end
        return pick;
    endfunction

    wr_state_t  r_wr_state;
    logic [1:0] r_wr_grant;
    logic       r_wr_last;
    logic       r_aw_done;
    logic       r_w_done;
    rd_state_t  r_rd_state;
    logic [1:0] r_rd_grant;
    logic       r_rd_last;

    logic       w_wr_sel1, w_rd_sel1;
    logic       w_wr_xfer, w_wr_resp, w_rd_xfer, w_rd_resp;
    logic       w_aw_open, w_w_open;
    logic       w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic [1:0] w_wr_pick, w_rd_pick;

    assign w_wr_sel1 = r_wr_grant[1];
    assign w_rd_sel1 = r_rd_grant[1];
    // Reset gates every valid/ready combinationally through these state qualifiers.
    assign w_wr_xfer = (r_wr_state == WR_XFER) && !rst;
    assign w_wr_resp = (r_wr_state == WR_RESP) && !rst;
    assign w_rd_xfer = (r_rd_state == RD_XFER) && !rst;
    assign w_rd_resp = (r_rd_state == RD_RESP) && !rst;
    assign w_aw_open = w_wr_xfer && !r_aw_done;
    assign w_w_open  = w_wr_xfer && !r_w_done;

    assign w_wr_pick = rr_pick({s01_axil_awvalid, s00_axil_awvalid}, r_wr_last);
    assign w_rd_pick = rr_pick({s01_axil_arvalid, s00_axil_arvalid}, r_rd_last);

    // Write request/data toward the shared slave; port 0 payload when idle.
    assign m_axil_awaddr  = w_wr_sel1 ? s01_axil_awaddr : s00_axil_awaddr;
    assign m_axil_awprot  = w_wr_sel1 ? s01_axil_awprot : s00_axil_awprot;
    assign m_axil_awvalid = w_aw_open && (w_wr_sel1 ? s01_axil_awvalid : s00_axil_awvalid);
    assign m_axil_wdata   = w_wr_sel1 ? s01_axil_wdata : s00_axil_wdata;
    assign m_axil_wstrb   = w_wr_sel1 ? s01_axil_wstrb : s00_axil_wstrb;
    assign m_axil_wvalid  = w_w_open && (w_wr_sel1 ? s01_axil_wvalid : s00_axil_wvalid);
    assign m_axil_bready  = w_wr_resp && (w_wr_sel1 ? s01_axil_bready : s00_axil_bready);

    assign s00_axil_awready = w_aw_open && r_wr_grant[0] && m_axil_awready;
    assign s01_axil_awready = w_aw_open && r_wr_grant[1] && m_axil_awready;
    assign s00_axil_wready  = w_w_open && r_wr_grant[0] && m_axil_wready;
    assign s01_axil_wready  = w_w_open && r_wr_grant[1] && m_axil_wready;
    assign s00_axil_bvalid  = w_wr_resp && r_wr_grant[0] && m_axil_bvalid;
    assign s01_axil_bvalid  = w_wr_resp && r_wr_grant[1] && m_axil_bvalid;
    assign s00_axil_bresp   = m_axil_bresp;
    assign s01_axil_bresp   = m_axil_bresp;

    // Read path mirrors the write path with a single address channel.
    assign m_axil_araddr  = w_rd_sel1 ? s01_axil_araddr : s00_axil_araddr;
    assign m_axil_arprot  = w_rd_sel1 ? s01_axil_arprot : s00_axil_arprot;
    assign m_axil_arvalid = w_rd_xfer && (w_rd_sel1 ? s01_axil_arvalid : s00_axil_arvalid);
    assign m_axil_rready  = w_rd_resp && (w_rd_sel1 ? s01_axil_rready : s00_axil_rready);

    assign s00_axil_arready = w_rd_xfer && r_rd_grant[0] && m_axil_arready;
    assign s01_axil_arready = w_rd_xfer && r_rd_grant[1] && m_axil_arready;
    assign s00_axil_rvalid  = w_rd_resp && r_rd_grant[0] && m_axil_rvalid;
    assign s01_axil_rvalid  = w_rd_resp && r_rd_grant[1] && m_axil_rvalid;
    assign s00_axil_rdata   = m_axil_rdata;
    assign s01_axil_rdata   = m_axil_rdata;
    assign s00_axil_rresp   = m_axil_rresp;
    assign s01_axil_rresp   = m_axil_rresp;

    assign w_aw_hs = m_axil_awvalid && m_axil_awready;
    assign w_w_hs  = m_axil_wvalid && m_axil_wready;
    assign w_b_hs  = m_axil_bvalid && m_axil_bready;
    assign w_ar_hs = m_axil_arvalid && m_axil_arready;
    assign w_r_hs  = m_axil_rvalid && m_axil_rready;

    assign wr_grant = r_wr_grant;
    assign rd_grant = r_rd_grant;

    // Write FSM: grant, track AW/W completion independently, then wait for B.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_state <= WR_IDLE;
            r_wr_grant <= 2'b00;
            r_wr_last  <= 1'b1;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
        end else begin
            case (r_wr_state)
                WR_IDLE: begin
                    if (w_wr_pick != 2'b00) begin
                        r_wr_grant <= w_wr_pick;
                        r_wr_last  <= w_wr_pick[1];
                        r_wr_state <= WR_XFER;
                    end
                end
                WR_XFER: begin
                    if (w_aw_hs) r_aw_done <= 1'b1;
                    if (w_w_hs)  r_w_done  <= 1'b1;
                    if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                        r_wr_state <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (w_b_hs) begin
                        r_wr_state <= WR_IDLE;
                        r_wr_grant <= 2'b00;
                        r_aw_done  <= 1'b0;
                        r_w_done   <= 1'b0;
                    end
                end
                default: begin
                    r_wr_state <= WR_IDLE;
                    r_wr_grant <= 2'b00;
                    r_aw_done  <= 1'b0;
                    r_w_done   <= 1'b0;
                end
            endcase
        end
    end

    // Read FSM: grant, AR handshake, then wait for R.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_state <= RD_IDLE;
            r_rd_grant <= 2'b00;
            r_rd_last  <= 1'b1;
        end else begin
            case (r_rd_state)
                RD_IDLE: begin
                    if (w_rd_pick != 2'b00) begin
                        r_rd_grant <= w_rd_pick;
                        r_rd_last  <= w_rd_pick[1];
                        r_rd_state <= RD_XFER;
                    end
                end
                RD_XFER: begin
                    if (w_ar_hs) r_rd_state <= RD_RESP;
                end
                RD_RESP: begin
                    if (w_r_hs) begin
                        r_rd_state <= RD_IDLE;
                        r_rd_grant <= 2'b00;
                    end
                end
                default: begin
                    r_rd_state <= RD_IDLE;
                    r_rd_grant <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axil_arb_2x1.sv
// Directed bench for axil_arb_2x1: grant timing, round-robin order, W-before-AW,
// concurrent read/write with a stalled R, and reset during a write response.
module tb_axil_arb_2x1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] s00_axil_awaddr, s01_axil_awaddr, m_axil_awaddr;
    logic [2:0]  s00_axil_awprot, s01_axil_awprot, m_axil_awprot;
    logic        s00_axil_awvalid, s01_axil_awvalid, m_axil_awvalid;
    logic        s00_axil_awready, s01_axil_awready, m_axil_awready;
    logic [31:0] s00_axil_wdata, s01_axil_wdata, m_axil_wdata;
    logic [3:0]  s00_axil_wstrb, s01_axil_wstrb, m_axil_wstrb;
    logic        s00_axil_wvalid, s01_axil_wvalid, m_axil_wvalid;
    logic        s00_axil_wready, s01_axil_wready, m_axil_wready;
    logic [1:0]  s00_axil_bresp, s01_axil_bresp, m_axil_bresp;
    logic        s00_axil_bvalid, s01_axil_bvalid, m_axil_bvalid;
    logic        s00_axil_bready, s01_axil_bready, m_axil_bready;
    logic [31:0] s00_axil_araddr, s01_axil_araddr, m_axil_araddr;
    logic [2:0]  s00_axil_arprot, s01_axil_arprot, m_axil_arprot;
    logic        s00_axil_arvalid, s01_axil_arvalid, m_axil_arvalid;
    logic        s00_axil_arready, s01_axil_arready, m_axil_arready;
    logic [31:0] s00_axil_rdata, s01_axil_rdata, m_axil_rdata;
    logic [1:0]  s00_axil_rresp, s01_axil_rresp, m_axil_rresp;
    logic        s00_axil_rvalid, s01_axil_rvalid, m_axil_rvalid;
    logic        s00_axil_rready, s01_axil_rready, m_axil_rready;
    logic [1:0]  wr_grant, rd_grant;

    int checks = 0;
    int failures = 0;

    axil_arb_2x1 dut (
        .clk(clk), .rst(rst),
        .s00_axil_awaddr(s00_axil_awaddr), .s00_axil_awprot(s00_axil_awprot),
        .s00_axil_awvalid(s00_axil_awvalid), .s00_axil_awready(s00_axil_awready),
        .s00_axil_wdata(s00_axil_wdata), .s00_axil_wstrb(s00_axil_wstrb),
        .s00_axil_wvalid(s00_axil_wvalid), .s00_axil_wready(s00_axil_wready),
        .s00_axil_bresp(s00_axil_bresp), .s00_axil_bvalid(s00_axil_bvalid),
        .s00_axil_bready(s00_axil_bready),
        .s00_axil_araddr(s00_axil_araddr), .s00_axil_arprot(s00_axil_arprot),
        .s00_axil_arvalid(s00_axil_arvalid), .s00_axil_arready(s00_axil_arready),
        .s00_axil_rdata(s00_axil_rdata), .s00_axil_rresp(s00_axil_rresp),
        .s00_axil_rvalid(s00_axil_rvalid), .s00_axil_rready(s00_axil_rready),
        .s01_axil_awaddr(s01_axil_awaddr), .s01_axil_awprot(s01_axil_awprot),
        .s01_axil_awvalid(s01_axil_awvalid), .s01_axil_awready(s01_axil_awready),
        .s01_axil_wdata(s01_axil_wdata), .s01_axil_wstrb(s01_axil_wstrb),
        .s01_axil_wvalid(s01_axil_wvalid), .s01_axil_wready(s01_axil_wready),
        .s01_axil_bresp(s01_axil_bresp), .s01_axil_bvalid(s01_axil_bvalid),
        .s01_axil_bready(s01_axil_bready),
        .s01_axil_araddr(s01_axil_araddr), .s01_axil_arprot(s01_axil_arprot),
        .s01_axil_arvalid(s01_axil_arvalid), .s01_axil_arready(s01_axil_arready),
        .s01_axil_rdata(s01_axil_rdata), .s01_axil_rresp(s01_axil_rresp),
        .s01_axil_rvalid(s01_axil_rvalid), .s01_axil_rready(s01_axil_rready),
        .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
        .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
        .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
        .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
        .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid),
        .m_axil_bready(m_axil_bready),
        .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
        .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
        .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
        .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready),
        .wr_grant(wr_grant), .rd_grant(rd_grant)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one write for port p whose AW/W are already asserted and master readies are 1.
    task automatic run_write(input int p, input logic [31:0] exp_addr, input string tag);
        @(negedge clk); #1;
        chk({tag, "_grant"}, 32'(wr_grant), (p == 0) ? 32'h1 : 32'h2);
        chk({tag, "_awaddr"}, m_axil_awaddr, exp_addr);
        @(negedge clk);
        if (p == 0) begin
            s00_axil_awvalid = 1'b0; s00_axil_wvalid = 1'b0;
        end else begin
            s01_axil_awvalid = 1'b0; s01_axil_wvalid = 1'b0;
        end
        m_axil_bvalid = 1'b1; s00_axil_bready = 1'b1; s01_axil_bready = 1'b1;
        #1;
        chk({tag, "_bvalid_own"}, 32'((p == 0) ? s00_axil_bvalid : s01_axil_bvalid), 32'h1);
        chk({tag, "_bvalid_other"}, 32'((p == 0) ? s01_axil_bvalid : s00_axil_bvalid), 32'h0);
        @(negedge clk);
        m_axil_bvalid = 1'b0;
        #1;
        chk({tag, "_idle"}, 32'(wr_grant), 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        s00_axil_awaddr = 32'h0; s00_axil_awprot = 3'd0; s00_axil_awvalid = 1'b0;
        s00_axil_wdata = 32'h0; s00_axil_wstrb = 4'hF; s00_axil_wvalid = 1'b0; s00_axil_bready = 1'b0;
        s00_axil_araddr = 32'h0; s00_axil_arprot = 3'd0; s00_axil_arvalid = 1'b0; s00_axil_rready = 1'b0;
        s01_axil_awaddr = 32'h0; s01_axil_awprot = 3'd0; s01_axil_awvalid = 1'b0;
        s01_axil_wdata = 32'h0; s01_axil_wstrb = 4'hF; s01_axil_wvalid = 1'b0; s01_axil_bready = 1'b0;
        s01_axil_araddr = 32'h0; s01_axil_arprot = 3'd0; s01_axil_arvalid = 1'b0; s01_axil_rready = 1'b0;
        m_axil_awready = 1'b0; m_axil_wready = 1'b0; m_axil_bresp = 2'b00; m_axil_bvalid = 1'b0;
        m_axil_arready = 1'b0; m_axil_rdata = 32'h0; m_axil_rresp = 2'b00; m_axil_rvalid = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_wr_grant", 32'(wr_grant), 32'h0);
        chk("rst_rd_grant", 32'(rd_grant), 32'h0);
        @(negedge clk); rst = 1'b0;

        // Single write on s00
        s00_axil_awaddr = 32'h100; s00_axil_awvalid = 1'b1;
        s00_axil_wdata = 32'h1111_1111; s00_axil_wvalid = 1'b1;
        m_axil_awready = 1'b1; m_axil_wready = 1'b1;
        #1;
        chk("w1_nogrant", 32'(wr_grant), 32'h0);
        chk("w1_no_awvalid", 32'(m_axil_awvalid), 32'h0);
        @(negedge clk); #1;
        chk("w1_grant", 32'(wr_grant), 32'h1);
        chk("w1_m_awvalid", 32'(m_axil_awvalid), 32'h1);
        chk("w1_m_wvalid", 32'(m_axil_wvalid), 32'h1);
        chk("w1_m_awaddr", m_axil_awaddr, 32'h100);
        chk("w1_m_wdata", m_axil_wdata, 32'h1111_1111);
        chk("w1_s00_awready", 32'(s00_axil_awready), 32'h1);
        chk("w1_s00_wready", 32'(s00_axil_wready), 32'h1);
        chk("w1_s01_awready", 32'(s01_axil_awready), 32'h0);
        @(negedge clk);
        s00_axil_awvalid = 1'b0; s00_axil_wvalid = 1'b0;
        m_axil_bvalid = 1'b1; s00_axil_bready = 1'b1; s01_axil_bready = 1'b0;
        #1;
        chk("w1_s00_bvalid", 32'(s00_axil_bvalid), 32'h1);
        chk("w1_s01_bvalid", 32'(s01_axil_bvalid), 32'h0);
        chk("w1_m_bready", 32'(m_axil_bready), 32'h1);
        chk("w1_grant_resp", 32'(wr_grant), 32'h1);
        @(negedge clk);
        m_axil_bvalid = 1'b0;
        #1;
        chk("w1_idle", 32'(wr_grant), 32'h0);

        // Simultaneous writes after reset: s00, then s01, then s00 again
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        s00_axil_awaddr = 32'h200; s00_axil_awvalid = 1'b1; s00_axil_wvalid = 1'b1;
        s01_axil_awaddr = 32'h300; s01_axil_awvalid = 1'b1; s01_axil_wvalid = 1'b1;
        run_write(0, 32'h200, "rr1");
        s00_axil_awaddr = 32'h210; s00_axil_awvalid = 1'b1; s00_axil_wvalid = 1'b1;
        run_write(1, 32'h300, "rr2");
        run_write(0, 32'h210, "rr3");

        // W two cycles ahead of AW on s01
        @(negedge clk);
        s01_axil_wdata = 32'h2222_2222; s01_axil_wvalid = 1'b1;
        #1;
        chk("wf_nogrant0", 32'(wr_grant), 32'h0);
        @(negedge clk); #1;
        chk("wf_nogrant1", 32'(wr_grant), 32'h0);
        chk("wf_no_wready", 32'(s01_axil_wready), 32'h0);
        @(negedge clk);
        s01_axil_awaddr = 32'h400; s01_axil_awvalid = 1'b1;
        #1;
        chk("wf_nogrant2", 32'(wr_grant), 32'h0);
        @(negedge clk);
        m_axil_awready = 1'b0; m_axil_wready = 1'b1;
        #1;
        chk("wf_grant", 32'(wr_grant), 32'h2);
        chk("wf_m_wvalid", 32'(m_axil_wvalid), 32'h1);
        chk("wf_s01_wready", 32'(s01_axil_wready), 32'h1);
        chk("wf_s01_awready_stall", 32'(s01_axil_awready), 32'h0);
        @(negedge clk);
        m_axil_awready = 1'b1; m_axil_bvalid = 1'b1; s01_axil_bready = 1'b1;
        #1;
        chk("wf_w_masked", 32'(m_axil_wvalid), 32'h0);
        chk("wf_no_bvalid_yet", 32'(s01_axil_bvalid), 32'h0);
        chk("wf_no_bready_yet", 32'(m_axil_bready), 32'h0);
        chk("wf_s01_awready", 32'(s01_axil_awready), 32'h1);
        @(negedge clk);
        s01_axil_awvalid = 1'b0; s01_axil_wvalid = 1'b0;
        #1;
        chk("wf_s01_bvalid", 32'(s01_axil_bvalid), 32'h1);
        chk("wf_m_bready", 32'(m_axil_bready), 32'h1);
        @(negedge clk);
        m_axil_bvalid = 1'b0;
        #1;
        chk("wf_idle", 32'(wr_grant), 32'h0);

        // Write on s00 concurrent with read on s01, R stalled
        @(negedge clk);
        s00_axil_awaddr = 32'h500; s00_axil_awvalid = 1'b1; s00_axil_wvalid = 1'b1;
        s01_axil_araddr = 32'h600; s01_axil_arvalid = 1'b1;
        s00_axil_rready = 1'b1; s01_axil_rready = 1'b1; m_axil_arready = 1'b1;
        m_axil_rdata = 32'hDEAD_BEEF; m_axil_rresp = 2'b00; m_axil_rvalid = 1'b0;
        #1;
        chk("cc_nogrant_rd", 32'(rd_grant), 32'h0);
        @(negedge clk); #1;
        chk("cc_wr_grant", 32'(wr_grant), 32'h1);
        chk("cc_rd_grant", 32'(rd_grant), 32'h2);
        chk("cc_m_araddr", m_axil_araddr, 32'h600);
        chk("cc_m_arvalid", 32'(m_axil_arvalid), 32'h1);
        chk("cc_s01_arready", 32'(s01_axil_arready), 32'h1);
        chk("cc_s00_arready", 32'(s00_axil_arready), 32'h0);
        @(negedge clk);
        s00_axil_awvalid = 1'b0; s00_axil_wvalid = 1'b0; s01_axil_arvalid = 1'b0;
        m_axil_bvalid = 1'b1;
        #1;
        chk("cc_s00_bvalid", 32'(s00_axil_bvalid), 32'h1);
        chk("cc_rstall_first", 32'(s01_axil_rvalid), 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            m_axil_bvalid = 1'b0;
            #1;
            chk("cc_rstall_rvalid", 32'(s01_axil_rvalid), 32'h0);
            chk("cc_rstall_grant", 32'(rd_grant), 32'h2);
        end
        @(negedge clk);
        m_axil_rvalid = 1'b1;
        #1;
        chk("cc_s01_rvalid", 32'(s01_axil_rvalid), 32'h1);
        chk("cc_s00_rvalid", 32'(s00_axil_rvalid), 32'h0);
        chk("cc_s01_rdata", s01_axil_rdata, 32'hDEAD_BEEF);
        chk("cc_s01_rresp", 32'(s01_axil_rresp), 32'h0);
        chk("cc_s00_rdata", s00_axil_rdata, 32'hDEAD_BEEF);
        chk("cc_m_rready", 32'(m_axil_rready), 32'h1);
        chk("cc_wr_idle", 32'(wr_grant), 32'h0);
        @(negedge clk);
        m_axil_rvalid = 1'b0;
        #1;
        chk("cc_rd_idle", 32'(rd_grant), 32'h0);

        // Reset during WR_RESP; afterwards s00 wins against s01
        @(negedge clk);
        s00_axil_awaddr = 32'h700; s00_axil_awvalid = 1'b1; s00_axil_wvalid = 1'b1;
        @(negedge clk); #1;
        chk("rr_pre_grant", 32'(wr_grant), 32'h1);
        @(negedge clk);
        s00_axil_awaddr = 32'h900;
        s01_axil_awaddr = 32'h800; s01_axil_awvalid = 1'b1; s01_axil_wvalid = 1'b1;
        m_axil_bvalid = 1'b1; s00_axil_bready = 1'b1; rst = 1'b1;
        #1;
        chk("rs_s00_bvalid", 32'(s00_axil_bvalid), 32'h0);
        chk("rs_m_bready", 32'(m_axil_bready), 32'h0);
        chk("rs_m_awvalid", 32'(m_axil_awvalid), 32'h0);
        chk("rs_m_wvalid", 32'(m_axil_wvalid), 32'h0);
        chk("rs_s00_awready", 32'(s00_axil_awready), 32'h0);
        chk("rs_s01_wready", 32'(s01_axil_wready), 32'h0);
        @(negedge clk);
        rst = 1'b0; m_axil_bvalid = 1'b0;
        #1;
        chk("rs_grant_cleared", 32'(wr_grant), 32'h0);
        run_write(0, 32'h900, "rs_next");
        run_write(1, 32'h800, "rs_s01");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
